scanline_composer: RTL and testbench
====================================

# scanline_composer

Writer side of the display scanline path. The VGA frame-buffer display consumes one packed 2-bit-per-pixel, 848-pixel line per video line; this block builds that line. On each line request it latches the map background row, overlays the 57×57 ant sprite, and publishes the result through a ping-pong buffer. Sprite rows are fetched from the sprite-rotation engine's row store, one row index per line.

## Interface
- `H_PIX`, 848: visible pixels per line; the line word is `2*H_PIX` = 1696 bits.
- `V_PIX`, 480: visible lines.
- `SPR_W`, 57: sprite width and height in pixels.
- `SPR_COLOR`, 2'd2: pixel code written where a sprite bit is 1 (0 black, 1 red, 2 green, 3 blue).
- `pixelCLK`  in  1  pixel clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `line_req`  in  1  one-cycle pulse, issued at the display's new-line point.
- `line_num`  in  9  index of the visible line to compose, 0..479.
- `bg_data`  in  1696  map background row for `line_num`; combinational from the map generator and stable while busy.
- `img_x`  in  11  sprite anchor column (unsigned).
- `img_y`  in  11  sprite anchor row (unsigned).
- `spr_row_idx`  out  6  sprite row requested, 0..56.
- `spr_row_data`  in  57  sprite row; bit c is column c; valid one cycle after `spr_row_idx` changes.
- `line_data`  out  1696  published line; pixel p occupies bits [2p+1:2p].
- `line_valid`  out  1  one-cycle pulse when a new `line_data` is published.
- `busy`  out  1  high while composing.
- `overrun`  out  1  sticky; set when a `line_req` arrives while busy.

## Operation
- FSM states: IDLE, FETCH, LOAD, PAINT, PUBLISH.
- **IDLE**
  - On `line_req`, latch `line_num`, `img_x` and `img_y` into L, X and Y.
  - Compute the sprite row r = L − (Y − 28) in signed 12-bit arithmetic.
  - In-range flag `hit` = (0 ≤ r ≤ 56). Drive `spr_row_idx` = r[5:0] when `hit`, otherwise hold it.
  - Go to FETCH.
- **FETCH**: copy `bg_data` into the write half W of the ping-pong buffer.
  - If `hit` = 0, go to PUBLISH.
  - Otherwise, capture `spr_row_data` into S, set column counter c = 0, go to PAINT.
- **LOAD**: reserved, never entered; FETCH goes directly to PAINT or PUBLISH.
- **PAINT**: one sprite column per cycle.
  - Screen column x = X − 24 + c, signed 12-bit.
  - If S[c] = 1 and 0 ≤ x < 848, write `SPR_COLOR` into W pixel x.
  - Increment c. After c = 56, go to PUBLISH.
- **PUBLISH**: swap the halves so `line_data` now shows W, pulse `line_valid`, go to IDLE.
- Pixels outside `H_PIX` are clipped. A `line_num` ≥ `V_PIX` is composed as background only (`hit` forced to 0).
- `line_req` while not IDLE is ignored, sets `overrun`, and leaves the current composition intact.
- `overrun` clears only on `RST`.

## Timing
- Latency from `line_req` to `line_valid`:
  - with a sprite: 1 (IDLE) + 1 (FETCH) + 57 (PAINT) + 1 (PUBLISH) = 60 cycles;
  - without a sprite: 3 cycles.
- Both are well inside the 1088-cycle line period.
- `line_data` changes only on the PUBLISH edge. It is stable for the whole following line, and the display samples it at its next new-line point.
- `line_valid` is high in the cycle after the PUBLISH edge, for exactly one cycle.
- Reset values:
  - FSM in IDLE;
  - `line_data` = 0 (both halves);
  - `line_valid` = 0, `busy` = 0, `overrun` = 0;
  - `spr_row_idx` = 0.
- `RST` mid-composition aborts immediately, with no `line_valid` pulse and the buffers cleared.
- `line_req` in the same cycle as `RST`: `RST` wins and the request is dropped.

## Structure
- A shared package holds `H_PIX`, `V_PIX`, `SPR_W`, the 2-bit colour codes (BLACK, RED, GREEN, BLUE), and the FSM state encoding. The display module uses the same constants.
- One sub-module is natural: `pingpong_line_buf`, holding two 1696-bit halves with a per-pixel write port, a bulk load, a swap strobe, and a read-side output.

## Test plan
- Reset, then `line_req` with `line_num`=100 and `img_y`=300 (no hit), `bg_data` = all pixels 1 → `line_valid` 3 cycles later; `line_data` = all 1s; `spr_row_idx` stays 0.
- `img_x`=80, `img_y`=80, `line_num`=80, sprite row 28 = bit 0 only, background 0 → `spr_row_idx`=28; after 60 cycles, pixel 56 = 2 and every other pixel = 0.
- `img_x`=10, sprite row all 1s, on a hit line → pixels 0..42 = 2 and pixels 43..847 = background; the 14 columns at x < 0 produce no write.
- `img_x`=840, sprite row all 1s → pixels 816..847 = 2 and no wrap to column 0.
- Second `line_req` 20 cycles after the first → `overrun`=1; the first line still publishes at cycle 60; exactly one `line_valid` pulse.
- `RST` asserted at cycle 30 of a composition → no `line_valid`; `line_data`=0; next `line_req` completes normally in 60 cycles.

Source files
------------

// File: rtl/scanline_composer_pkg.sv
// Shared constants, colour codes and composer state encoding for the
// scanline path; the display side imports the same package.
package scanline_composer_pkg;

  localparam int unsigned H_PIX    = 848;
  localparam int unsigned V_PIX    = 480;
  localparam int unsigned SPR_W    = 57;
  localparam int unsigned LINE_W   = 2 * H_PIX;
  // Sprite anchor sits 28 rows below its top edge and 24 columns right of its left edge.
  localparam int unsigned SPR_YOFF = 28;
  localparam int unsigned SPR_XOFF = 24;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_t;

  localparam color_t SPR_COLOR = GREEN;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PAINT,
    PUBLISH
  } state_t;

endpackage

// File: rtl/scanline_composer_pingpong.sv
// Two-half line buffer: one half is shown on rd_data while the other is
// bulk-loaded and pixel-painted; swap exchanges the roles.
module pingpong_line_buf
  import scanline_composer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr,
  input  logic [9:0]        wr_pix,
  input  logic [1:0]        wr_color,
  input  logic              swap,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] half_a;
  logic [LINE_W-1:0] half_b;
  logic              rd_sel;  // 0: half_a is displayed, half_b is written

  always_ff @(posedge clk) begin
    if (rst) begin
      half_a <= '0;
      half_b <= '0;
      rd_sel <= 1'b0;
    end else begin
      if (swap) rd_sel <= ~rd_sel;
      if (rd_sel) begin
        if (load)    half_a <= load_data;
        else if (wr) half_a[{wr_pix, 1'b0} +: 2] <= wr_color;
      end else begin
        if (load)    half_b <= load_data;
        else if (wr) half_b[{wr_pix, 1'b0} +: 2] <= wr_color;
      end
    end
  end

  assign rd_data = rd_sel ? half_b : half_a;

endmodule

// File: rtl/scanline_composer.sv
// Builds one 2-bpp display line per request: background row, then the ant
// sprite painted one column per cycle, then published via the ping-pong buffer.
module scanline_composer
  import scanline_composer_pkg::*;
(
  input  logic              pixelCLK,
  input  logic              RST,
  input  logic              line_req,
  input  logic [8:0]        line_num,
  input  logic [LINE_W-1:0] bg_data,
  input  logic [10:0]       img_x,
  input  logic [10:0]       img_y,
  output logic [5:0]        spr_row_idx,
  input  logic [SPR_W-1:0]  spr_row_data,
  output logic [LINE_W-1:0] line_data,
  output logic              line_valid,
  output logic              busy,
  output logic              overrun
);

  state_t             state, state_next;
  logic [10:0]        x_anchor;
  logic               hit;
  logic [SPR_W-1:0]   spr_bits;
  logic [5:0]         col;
  logic signed [11:0] row_off;
  logic signed [11:0] px;
  logic               row_hit;
  logic               px_in;
  logic               last_col;
  logic               load;
  logic               wr;
  logic               swap;

  // Only the 12-bit signed result matters; lines past V_PIX never hit.
  assign row_off  = $signed({3'b0, line_num})
                  - ($signed({1'b0, img_y}) - $signed(12'(SPR_YOFF)));
  assign row_hit  = !row_off[11] && (row_off <= $signed(12'(SPR_W - 1)))
                 && (line_num < 9'(V_PIX));

  assign px       = $signed({1'b0, x_anchor}) - $signed(12'(SPR_XOFF))
                  + $signed({6'b0, col});
  assign px_in    = !px[11] && (px < $signed(12'(H_PIX)));
  assign last_col = (col == 6'(SPR_W - 1));

  always_ff @(posedge pixelCLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    wr         = 1'b0;
    swap       = 1'b0;
    unique case (state)
      IDLE:    if (line_req) state_next = FETCH;
      FETCH: begin
        load       = 1'b1;
        state_next = hit ? PAINT : PUBLISH;
      end
      PAINT: begin
        wr = spr_bits[col] && px_in;
        if (last_col) state_next = PUBLISH;
      end
      PUBLISH: begin
        swap       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixelCLK) begin
    if (RST) begin
      x_anchor    <= '0;
      hit         <= 1'b0;
      spr_bits    <= '0;
      col         <= '0;
      spr_row_idx <= '0;
      line_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      line_valid <= swap;
      if (line_req && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && line_req) begin
        x_anchor <= img_x;
        hit      <= row_hit;
        if (row_hit) spr_row_idx <= row_off[5:0];
      end
      if (load) begin
        spr_bits <= spr_row_data;
        col      <= '0;
      end else if (state == PAINT) begin
        col <= col + 6'd1;
      end
    end
  end

  assign busy = (state != IDLE);

  pingpong_line_buf u_buf (
    .clk       (pixelCLK),
    .rst       (RST),
    .load      (load),
    .load_data (bg_data),
    .wr        (wr),
    .wr_pix    (px[9:0]),
    .wr_color  (SPR_COLOR),
    .swap      (swap),
    .rd_data   (line_data)
  );

endmodule

// File: tb/tb_scanline_composer.sv
// Directed bench for scanline_composer with hand-derived expected lines.
module tb_scanline_composer;
  import scanline_composer_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_req;
  logic [8:0]        line_num;
  logic [LINE_W-1:0] bg_data;
  logic [10:0]       img_x;
  logic [10:0]       img_y;
  logic [5:0]        spr_row_idx;
  logic [SPR_W-1:0]  spr_row_data;
  logic [LINE_W-1:0] line_data;
  logic              line_valid;
  logic              busy;
  logic              overrun;

  logic [SPR_W-1:0]  row_store [0:SPR_W-1];
  int                vectors     = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    spr_row_data = '0;
    if (spr_row_idx < 6'(SPR_W)) spr_row_data = row_store[spr_row_idx];
  end

  scanline_composer dut (
    .pixelCLK     (clk),
    .RST          (rst),
    .line_req     (line_req),
    .line_num     (line_num),
    .bg_data      (bg_data),
    .img_x        (img_x),
    .img_y        (img_y),
    .spr_row_idx  (spr_row_idx),
    .spr_row_data (spr_row_data),
    .line_data    (line_data),
    .line_valid   (line_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    int p;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (got[LINE_W-1:64] == '0 && exp[LINE_W-1:64] == '0) begin
        $display("FAIL %s: got %0d required %0d", tag, got[63:0], exp[63:0]);
      end else begin
        p = 0;
        for (int i = H_PIX - 1; i >= 0; i--)
          if (got[2*i +: 2] !== exp[2*i +: 2]) p = i;
        $display("FAIL %s: pixel %0d got %0d required %0d", tag, p,
                 got[2*p +: 2], exp[2*p +: 2]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] fill(input logic [1:0] c);
    logic [LINE_W-1:0] v;
    for (int i = 0; i < H_PIX; i++) v[2*i +: 2] = c;
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] paint(input logic [LINE_W-1:0] v,
                                              input int lo, input int hi,
                                              input logic [1:0] c);
    logic [LINE_W-1:0] r;
    r = v;
    for (int i = lo; i <= hi; i++) r[2*i +: 2] = c;
    return r;
  endfunction

  function automatic logic [SPR_W-1:0] ones57();
    logic [SPR_W-1:0] v;
    v = '1;
    return v;
  endfunction

  // Issues a request and watches 100 cycles; optional second request / reset.
  task automatic run_line(input int req2_at, input int rst_at,
                          output int lat, output int pulses);
    lat      = 0;
    pulses   = 0;
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (line_valid) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      line_req = (n == req2_at);
      rst      = (n == rst_at);
      tick();
    end
    line_req = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pulses;
    for (int i = 0; i < SPR_W; i++) row_store[i] = '0;
    rst = 1'b1; line_req = 1'b0; line_num = '0; bg_data = '0;
    img_x = '0; img_y = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid",   line_valid,  0);
    check("rst_busy",    busy,        0);
    check("rst_overrun", overrun,     0);
    check("rst_idx",     spr_row_idx, 0);
    check("rst_line",    line_data,   '0);

    // No sprite on this line: background passes straight through.
    line_num = 9'd100; img_y = 11'd300; img_x = 11'd80; bg_data = fill(2'd1);
    run_line(-1, -1, lat, pulses);
    check("nohit_lat",    lat,         3);
    check("nohit_pulses", pulses,      1);
    check("nohit_line",   line_data,   fill(2'd1));
    check("nohit_idx",    spr_row_idx, 0);

    // Row 28, only column 0 set: x = 80 - 24 + 0 = 56.
    row_store[28] = 57'd1;
    line_num = 9'd80; img_y = 11'd80; img_x = 11'd80; bg_data = '0;
    run_line(-1, -1, lat, pulses);
    check("hit_idx",  spr_row_idx, 28);
    check("hit_lat",  lat,         60);
    check("hit_line", line_data,   paint('0, 56, 56, 2'd2));

    // Left clip: columns 0..13 fall at x < 0.
    row_store[28] = ones57();
    img_x = 11'd10; bg_data = fill(2'd3);
    run_line(-1, -1, lat, pulses);
    check("lclip_lat",  lat,       60);
    check("lclip_line", line_data, paint(fill(2'd3), 0, 42, 2'd2));

    // Right clip: x = 816..872, only 816..847 land.
    img_x = 11'd840; bg_data = '0;
    run_line(-1, -1, lat, pulses);
    check("rclip_lat",  lat,       60);
    check("rclip_line", line_data, paint('0, 816, 847, 2'd2));

    // Second request mid-composition is ignored and flagged.
    check("pre_overrun", overrun, 0);
    img_x = 11'd300; bg_data = fill(2'd1);
    run_line(20, -1, lat, pulses);
    check("ovr_flag",   overrun,   1);
    check("ovr_lat",    lat,       60);
    check("ovr_pulses", pulses,    1);
    check("ovr_line",   line_data, paint(fill(2'd1), 276, 332, 2'd2));

    // Reset at cycle 30 aborts with no publish and clears everything.
    img_x = 11'd80; bg_data = '0;
    run_line(-1, 30, lat, pulses);
    check("abort_pulses",  pulses,    0);
    check("abort_line",    line_data, '0);
    check("abort_overrun", overrun,   0);
    check("abort_busy",    busy,      0);
    run_line(-1, -1, lat, pulses);
    check("after_lat",  lat,       60);
    check("after_line", line_data, paint('0, 56, 112, 2'd2));

    // Request coincident with reset is dropped.
    rst = 1'b1; line_req = 1'b1;
    tick();
    rst = 1'b0; line_req = 1'b0;
    check("rstreq_busy", busy, 0);
    tick(); tick();
    check("rstreq_valid", line_valid, 0);
    check("rstreq_line",  line_data,  '0);

    // Line beyond V_PIX would give row 48 but is background only.
    line_num = 9'd500; img_y = 11'd480; img_x = 11'd100; bg_data = fill(2'd3);
    run_line(-1, -1, lat, pulses);
    check("vpix_lat",  lat,         3);
    check("vpix_line", line_data,   fill(2'd3));
    check("vpix_idx",  spr_row_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
